// File: rtl/rect_loop_reader_if.sv
// Output stream of the rectangle-loop reader: one matrix element per accepted beat,
// tagged with its (row, col) index and an end-of-rectangle marker.
interface rect_loop_reader_if #(
  parameter int unsigned DATA_W = 1
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/rect_loop_reader.sv
// Snapshots a ROWSxCOLS matrix and a loop descriptor on start, then streams the requested
// rectangle row-major over a valid/ready interface.
module rect_loop_reader #(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 2,
  parameter int unsigned DATA_W = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [11:0]                   param,
  input  logic [ROWS*COLS*DATA_W-1:0]   m_in,
  output logic                          busy,
  rect_loop_reader_if.master            out,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned MatW = ROWS * COLS * DATA_W;

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e            state_q, state_d;
  logic [MatW-1:0]   snap_q, snap_d;
  logic [2:0]        row_lo_q, row_lo_d, row_hi_q, row_hi_d;
  logic [2:0]        col_lo_q, col_lo_d, col_hi_q, col_hi_d;
  logic [2:0]        row_q, row_d, col_q, col_d;
  logic              done_q, done_d, err_q, err_d;

  logic [2:0]        p_row_lo, p_row_hi, p_col_lo, p_col_hi;
  logic              legal;
  logic              at_last;
  int unsigned       elem_base;

  assign p_row_lo = param[11:9];
  assign p_row_hi = param[8:6];
  assign p_col_lo = param[5:3];
  assign p_col_hi = param[2:0];

  assign legal = (p_row_lo <= p_row_hi) && (32'(p_row_hi) < ROWS) &&
                 (p_col_lo <= p_col_hi) && (32'(p_col_hi) < COLS);

  assign at_last = (row_q == row_hi_q) && (col_q == col_hi_q);

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    row_lo_d = row_lo_q;
    row_hi_d = row_hi_q;
    col_lo_d = col_lo_q;
    col_hi_d = col_hi_q;
    row_d    = row_q;
    col_d    = col_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The done cycle already sits in StIdle but must not relaunch.
        if (start && !done_q) begin
          snap_d   = m_in;
          row_lo_d = p_row_lo;
          row_hi_d = p_row_hi;
          col_lo_d = p_col_lo;
          col_hi_d = p_col_hi;
          if (legal) begin
            state_d = StStream;
            row_d   = p_row_lo;
            col_d   = p_col_lo;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StStream: begin
        if (out.out_ready) begin
          if (at_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (col_q < col_hi_q) begin
            col_d = col_q + 3'd1;
          end else begin
            col_d = col_lo_q;
            row_d = row_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      snap_q   <= '0;
      row_lo_q <= '0;
      row_hi_q <= '0;
      col_lo_q <= '0;
      col_hi_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      row_lo_q <= row_lo_d;
      row_hi_q <= row_hi_d;
      col_lo_q <= col_lo_d;
      col_hi_q <= col_hi_d;
      row_q    <= row_d;
      col_q    <= col_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    elem_base     = (32'(row_q) * COLS + 32'(col_q)) * DATA_W;
    out.out_data  = snap_q[elem_base +: DATA_W];
  end

  assign out.out_valid = (state_q == StStream);
  assign out.out_row   = row_q;
  assign out.out_col   = col_q;
  // Gated by valid so an idle reader never advertises a stale final beat.
  assign out.out_last  = out.out_valid && at_last;
  assign busy          = (state_q == StStream);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_rect_loop_reader.sv
// Directed bench for rect_loop_reader with a 2x2 single-bit matrix.
module tb_rect_loop_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] param;
  logic [3:0]  m_in;
  logic        busy, done, err;
  int          checks = 0;
  int          errors = 0;

  rect_loop_reader_if #(.DATA_W(1)) sif ();

  rect_loop_reader #(.ROWS(2), .COLS(2), .DATA_W(1)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .param (param),
    .m_in  (m_in),
    .busy  (busy),
    .out   (sif),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({busy, sif.out_valid, sif.out_last, done, err, sif.out_data, sif.out_row, sif.out_col}
        !== 11'b0) begin
      errors++;
      $display("FAIL %s: outputs=%b required all zero", name,
               {busy, sif.out_valid, sif.out_last, done, err, sif.out_data, sif.out_row,
                sif.out_col});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    param = '0;
    m_in  = '0;
    sif.out_ready = 1'b0;
    #2;
    check_idle_zero("reset_async");
    tick();
    check_idle_zero("reset_held");
    reset = 1'b0;
    tick();
    check_idle_zero("after_reset");
  endtask

  // Launches one walk and checks every beat against a row-major model of the rectangle.
  task automatic do_walk(input string name, input logic [11:0] p, input logic [3:0] m,
                         input bit stall, input bit clobber);
    logic [2:0] er[$];
    logic [2:0] ec[$];
    logic       ed[$];
    int         n, idx, k;
    logic       exp_last;
    for (int r = int'(p[11:9]); r <= int'(p[8:6]); r++) begin
      for (int c = int'(p[5:3]); c <= int'(p[2:0]); c++) begin
        er.push_back(3'(r));
        ec.push_back(3'(c));
        ed.push_back(m[r*2+c]);
      end
    end
    n = er.size();
    start = 1'b1;
    param = p;
    m_in  = m;
    sif.out_ready = 1'b1;
    tick();
    start = 1'b0;
    if (clobber) begin
      m_in  = 4'b0000;
      param = 12'h000;
    end
    idx = 0;
    k   = 0;
    while (idx < n && k < 64) begin
      sif.out_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      exp_last = (idx == n - 1);
      checks++;
      if (sif.out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid beat %0d: valid=%b busy=%b required 1 1", name, idx,
                 sif.out_valid, busy);
      end
      checks++;
      if ({sif.out_row, sif.out_col, sif.out_data, sif.out_last} !==
          {er[idx], ec[idx], ed[idx], exp_last}) begin
        errors++;
        $display("FAIL %s_beat %0d: row=%0d col=%0d data=%b last=%b required %0d %0d %b %b",
                 name, idx, sif.out_row, sif.out_col, sif.out_data, sif.out_last, er[idx],
                 ec[idx], ed[idx], exp_last);
      end
      if (sif.out_ready) idx++;
      k++;
      tick();
    end
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL %s_timeout: beats=%0d required %0d", name, idx, n);
    end
    sif.out_ready = 1'b0;
    checks++;
    if ({done, sif.out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL %s_done: done/valid/busy=%b required 100", name,
               {done, sif.out_valid, busy});
    end
    tick();
    checks++;
    if ({done, sif.out_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL %s_done_pulse: done/valid/busy=%b required 000", name,
               {done, sif.out_valid, busy});
    end
  endtask

  task automatic test_basic();
    do_walk("basic", 12'b000_001_000_001, 4'b1011, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    do_walk("stall", 12'b000_001_000_001, 4'b1011, 1'b1, 1'b0);
  endtask

  task automatic test_single_and_illegal();
    do_walk("single", 12'b001_001_000_000, 4'b0100, 1'b0, 1'b0);
    start = 1'b1;
    param = 12'b001_000_000_001;
    m_in  = 4'b1111;
    tick();
    start = 1'b0;
    checks++;
    if ({err, sif.out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_err: err/valid/busy=%b required 100", {err, sif.out_valid, busy});
    end
    tick();
    checks++;
    if ({err, sif.out_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL illegal_pulse: err/valid/busy=%b required 000",
               {err, sif.out_valid, busy});
    end
    start = 1'b1;
    param = 12'b000_000_000_010;
    tick();
    start = 1'b0;
    checks++;
    if ({err, sif.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_col_range: err/valid=%b required 10", {err, sif.out_valid});
    end
    tick();
  endtask

  task automatic test_snapshot();
    do_walk("snapshot", 12'b000_001_000_001, 4'b1011, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    param = 12'b000_001_000_001;
    m_in  = 4'b1011;
    sif.out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_idle_zero("reset_mid_async");
    tick();
    check_idle_zero("reset_mid_held");
    reset = 1'b0;
    sif.out_ready = 1'b0;
    tick();
    check_idle_zero("reset_mid_release");
    do_walk("after_abort", 12'b000_001_000_001, 4'b1011, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] rows[4] = '{3'd0, 3'd0, 3'd1, 3'd1};
    logic [2:0] cols[4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    int         k;
    start = 1'b1;
    param = 12'b000_001_000_001;
    m_in  = 4'b1011;
    sif.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({sif.out_valid, sif.out_row, sif.out_col} !== {1'b1, rows[i], cols[i]}) begin
        errors++;
        $display("FAIL b2b_beat %0d: valid=%b row=%0d col=%0d required 1 %0d %0d", i,
                 sif.out_valid, sif.out_row, sif.out_col, rows[i], cols[i]);
      end
      tick();
    end
    checks++;
    if ({done, sif.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_done: done/valid=%b required 10", {done, sif.out_valid});
    end
    tick();
    checks++;
    if ({done, sif.out_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_gap: done/valid/busy=%b required 000", {done, sif.out_valid, busy});
    end
    tick();
    checks++;
    if ({sif.out_valid, sif.out_row, sif.out_col} !== 7'b1_000_000) begin
      errors++;
      $display("FAIL b2b_relaunch: valid=%b row=%0d col=%0d required 1 0 0", sif.out_valid,
               sif.out_row, sif.out_col);
    end
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done: done=%b required 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single_and_illegal();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
